// File: rtl/stats_uart_pkg.sv
// Shared constants for the stats UART frame transmitter and its byte serializer.
// Frame layout: header, five 5-bit stats, sleep flag, XOR checksum of the payload.
package stats_uart_pkg;

    localparam int FRAME_LEN     = 8;
    localparam int BITS_PER_BYTE = 8;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Byte slots within a frame.
    localparam logic [2:0] IDX_HEADER    = 3'd0;
    localparam logic [2:0] IDX_HUNGER    = 3'd1;
    localparam logic [2:0] IDX_HAPPINESS = 3'd2;
    localparam logic [2:0] IDX_HYGIENE   = 3'd3;
    localparam logic [2:0] IDX_ENERGY    = 3'd4;
    localparam logic [2:0] IDX_SOCIAL    = 3'd5;
    localparam logic [2:0] IDX_SLEEP     = 3'd6;
    localparam logic [2:0] IDX_CHECKSUM  = 3'd7;

    function automatic logic [7:0] pad_stat(input logic [4:0] value);
        return {3'b000, value};
    endfunction

endpackage

// File: rtl/stats_uart_tx_if.sv
// Stat inputs, send request and serial-side status of the stats UART transmitter.
// The pet logic is the master; the transmitter is the slave.
interface stats_uart_tx_if;

    logic       send;
    logic [4:0] hunger;
    logic [4:0] happiness;
    logic [4:0] hygiene;
    logic [4:0] energy;
    logic [4:0] social;
    logic       is_sleeping;
    logic       uart_tx;
    logic       busy;
    logic       done;

    modport master (
        output send, hunger, happiness, hygiene, energy, social, is_sleeping,
        input  uart_tx, busy, done
    );

    modport slave (
        input  send, hunger, happiness, hygiene, energy, social, is_sleeping,
        output uart_tx, busy, done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high. A byte offered during the last cycle
// of a stop bit is taken immediately so back-to-back bytes leave no idle gap.
module uart_tx_byte import stats_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

    // tx is registered and updated on the same edge as the state, so the line never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (valid) begin
                        state     <= ST_START;
                        shift_reg <= data;
                        tx        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (valid) begin
                            state     <= ST_START;
                            shift_reg <= data;
                            tx        <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/stats_uart_tx.sv
// Sends a snapshot of the pet stats as an 8-byte UART frame on each accepted send.
// Holds the snapshot, picks the next byte and sequences the frame over uart_tx_byte.
module stats_uart_tx import stats_uart_pkg::*; #(
    parameter int         CLKS_PER_BIT = 1042,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic           clk,
    input  logic           reset,
    stats_uart_tx_if.slave bus
);

    logic [4:0] snap_hunger;
    logic [4:0] snap_happiness;
    logic [4:0] snap_hygiene;
    logic [4:0] snap_energy;
    logic [4:0] snap_social;
    logic       snap_sleeping;

    logic [2:0] byte_idx;
    logic [2:0] next_idx;
    logic       busy_q;
    logic       done_q;
    logic       accept;
    logic       frame_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_line;
    logic [7:0] tx_data;
    logic [7:0] checksum;

    assign accept     = bus.send && !busy_q;
    assign next_idx   = byte_idx + 3'd1;
    assign frame_last = (byte_idx == 3'(FRAME_LEN - 1));

    assign checksum = pad_stat(snap_hunger) ^ pad_stat(snap_happiness) ^
                      pad_stat(snap_hygiene) ^ pad_stat(snap_energy) ^
                      pad_stat(snap_social) ^ {7'b0, snap_sleeping};

    // The header needs no snapshot, so it can be handed over on the accepting edge itself.
    always_comb begin
        tx_data = HEADER;
        if (busy_q) begin
            case (next_idx)
                IDX_HEADER:    tx_data = HEADER;
                IDX_HUNGER:    tx_data = pad_stat(snap_hunger);
                IDX_HAPPINESS: tx_data = pad_stat(snap_happiness);
                IDX_HYGIENE:   tx_data = pad_stat(snap_hygiene);
                IDX_ENERGY:    tx_data = pad_stat(snap_energy);
                IDX_SOCIAL:    tx_data = pad_stat(snap_social);
                IDX_SLEEP:     tx_data = {7'b0, snap_sleeping};
                IDX_CHECKSUM:  tx_data = checksum;
                default:       tx_data = HEADER;
            endcase
        end
    end

    assign tx_valid = busy_q ? (tx_ready && !frame_last) : bus.send;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            byte_idx       <= '0;
            snap_hunger    <= '0;
            snap_happiness <= '0;
            snap_hygiene   <= '0;
            snap_energy    <= '0;
            snap_social    <= '0;
            snap_sleeping  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q         <= 1'b1;
                byte_idx       <= IDX_HEADER;
                snap_hunger    <= bus.hunger;
                snap_happiness <= bus.happiness;
                snap_hygiene   <= bus.hygiene;
                snap_energy    <= bus.energy;
                snap_social    <= bus.social;
                snap_sleeping  <= bus.is_sleeping;
            end else if (busy_q && tx_ready) begin
                if (frame_last) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= next_idx;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .reset (reset),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .tx    (tx_line)
    );

    assign bus.uart_tx = tx_line;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_stats_uart_tx.sv
// Directed bench for stats_uart_tx: a bit-stream model is compared every cycle,
// and captured frames are decoded and pinned to hand-computed bytes.
`timescale 1ns/1ps
module tb_stats_uart_tx;

    localparam int C         = 4;
    localparam int FRAME_CYC = 80 * C;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    bit   cmp_en = 1'b0;

    logic       line_log [FRAME_CYC];
    logic [7:0] exp_bytes [8];

    stats_uart_tx_if bus();

    stats_uart_tx #(
        .CLKS_PER_BIT(C),
        .HEADER      (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] hu, input logic [4:0] ha, input logic [4:0] hy,
                                 input logic [4:0] en, input logic [4:0] so, input logic sl);
        bus.hunger      = hu;
        bus.happiness   = ha;
        bus.hygiene     = hy;
        bus.energy      = en;
        bus.social      = so;
        bus.is_sleeping = sl;
    endtask

    task automatic set_expected(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                input logic [7:0] b6, input logic [7:0] b7);
        exp_bytes[0] = b0; exp_bytes[1] = b1; exp_bytes[2] = b2; exp_bytes[3] = b3;
        exp_bytes[4] = b4; exp_bytes[5] = b5; exp_bytes[6] = b6; exp_bytes[7] = b7;
    endtask

    // Model: on acceptance the whole frame is expanded into one line value per clock cycle.
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic line_q [$];

    task automatic build_frame();
        logic [7:0] b [8];
        b[0] = 8'hA5;
        b[1] = {3'b0, bus.hunger};
        b[2] = {3'b0, bus.happiness};
        b[3] = {3'b0, bus.hygiene};
        b[4] = {3'b0, bus.energy};
        b[5] = {3'b0, bus.social};
        b[6] = {7'b0, bus.is_sleeping};
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 10; j++) begin
                logic v;
                if (j == 0)      v = 1'b0;
                else if (j == 9) v = 1'b1;
                else             v = b[i][j-1];
                repeat (C) line_q.push_back(v);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin : model_p
        bit go;
        if (reset) begin
            line_q.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            go     = bus.send && !m_busy;
            m_done = 1'b0;
            if (go) build_frame();
            if (line_q.size() > 0) begin
                m_tx   = line_q.pop_front();
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_tx   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            checkOutput("model_tx",   int'(bus.uart_tx), int'(m_tx));
            checkOutput("model_busy", int'(bus.busy),    int'(m_busy));
            checkOutput("model_done", int'(bus.done),    int'(m_done));
        end
    end

    // Caller raises send on a negedge; the following posedge is the accepting edge.
    task automatic capture_frame(input int pulse_a, input int pulse_b, input bit scramble, input bit chain);
        int         busy_cycles;
        int         bad_runs;
        int         run_len;
        logic [7:0] got;
        busy_cycles = 0;
        @(posedge clk);
        for (int n = 0; n < FRAME_CYC; n++) begin
            @(negedge clk);
            bus.send = (n == pulse_a) || (n == pulse_b);
            if (n == 0) begin
                checkOutput("accept_busy",  int'(bus.busy),    1);
                checkOutput("accept_start", int'(bus.uart_tx), 0);
                checkOutput("done_single",  int'(bus.done),    0);
                if (scramble)
                    applyStimulus(~bus.hunger, ~bus.happiness, ~bus.hygiene,
                                  ~bus.energy, ~bus.social, ~bus.is_sleeping);
            end
            line_log[n] = bus.uart_tx;
            if (bus.busy) busy_cycles++;
        end
        @(negedge clk);
        bus.send = chain;
        checkOutput("done_pulse",  int'(bus.done),    1);
        checkOutput("end_busy",    int'(bus.busy),    0);
        checkOutput("end_line",    int'(bus.uart_tx), 1);
        checkOutput("busy_cycles", busy_cycles,       FRAME_CYC);
        for (int i = 0; i < 8; i++) begin
            int base;
            base = i * 10 * C + C / 2;
            got  = '0;
            for (int j = 0; j < 8; j++) got[j] = line_log[base + (j + 1) * C];
            checkOutput($sformatf("start_bit%0d", i), int'(line_log[base]), 0);
            checkOutput($sformatf("stop_bit%0d", i),  int'(line_log[base + 9 * C]), 1);
            checkOutput($sformatf("byte%0d", i),      int'(got), int'(exp_bytes[i]));
        end
        bad_runs = 0;
        run_len  = 1;
        for (int n = 1; n < FRAME_CYC; n++) begin
            if (line_log[n] == line_log[n-1]) begin
                run_len++;
            end else begin
                if (run_len % C != 0) bad_runs++;
                run_len = 1;
            end
        end
        checkOutput("run_lengths", bad_runs, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, n_err %0d", n_err);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idle_busy;
        int idle_low;
        int done_seen;

        bus.send = 1'b0;
        applyStimulus(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx",   int'(bus.uart_tx), 1);
        checkOutput("reset_busy", int'(bus.busy),    0);
        checkOutput("reset_done", int'(bus.done),    0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] frame with mixed stats, sleeping");
        applyStimulus(5'h0A, 5'h1F, 5'h00, 5'h07, 5'h11, 1'b1);
        set_expected(8'hA5, 8'h0A, 8'h1F, 8'h00, 8'h07, 8'h11, 8'h01, 8'h02);
        bus.send = 1'b1;
        capture_frame(-1, -1, 1'b0, 1'b0);

        $display("[TB] all stats max, awake, then back-to-back frame");
        @(negedge clk);
        applyStimulus(5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1'b0);
        set_expected(8'hA5, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h00, 8'h1F);
        bus.send = 1'b1;
        capture_frame(-1, -1, 1'b0, 1'b1);
        capture_frame(-1, -1, 1'b0, 1'b0);

        $display("[TB] snapshot held, sends during frame and on done ignored");
        @(negedge clk);
        applyStimulus(5'h03, 5'h05, 5'h09, 5'h11, 5'h1E, 1'b0);
        set_expected(8'hA5, 8'h03, 8'h05, 8'h09, 8'h11, 8'h1E, 8'h00, 8'h00);
        bus.send = 1'b1;
        capture_frame(3 * 10 * C + 6, FRAME_CYC - 1, 1'b1, 1'b0);
        idle_busy = 0;
        idle_low  = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
            if (!bus.uart_tx) idle_low++;
        end
        checkOutput("no_queued_frame", idle_busy, 0);
        checkOutput("idle_line_high",  idle_low,  0);

        $display("[TB] reset in the middle of byte 4");
        applyStimulus(5'h0A, 5'h1F, 5'h00, 5'h07, 5'h11, 1'b1);
        bus.send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4 * 10 * C + 2 * C) @(negedge clk);
        checkOutput("pre_reset_busy", int'(bus.busy), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_tx",   int'(bus.uart_tx), 1);
        checkOutput("async_reset_busy", int'(bus.busy),    0);
        checkOutput("async_reset_done", int'(bus.done),    0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (FRAME_CYC) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checkOutput("no_done_after_abort", done_seen, 0);

        set_expected(8'hA5, 8'h0A, 8'h1F, 8'h00, 8'h07, 8'h11, 8'h01, 8'h02);
        bus.send = 1'b1;
        capture_frame(-1, -1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
